// File: rtl/prga_fifo_sync.sv
// Single-clock FIFO with selectable lookahead (FWFT) or registered-read semantics.
// CONVERTED=1 runs the core in the opposite mode and adapts it with a one-entry stage.

module prga_fifo_core #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 9,
    parameter int LOOKAHEAD  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  full,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  empty,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2:0]   wptr, rptr, count;
    logic                  wr_en, rd_en;

    assign count = wptr - rptr;
    assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (wptr == rptr);
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[DEPTH_LOG2-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    if (LOOKAHEAD != 0) begin : g_la
        // Head is presented combinationally; masked to zero while nothing is stored.
        assign dout = empty ? '0 : mem[rptr[DEPTH_LOG2-1:0]];
    end else begin : g_nla
        logic [DATA_WIDTH-1:0] dout_q;
        always_ff @(posedge clk) begin
            if (rst)        dout_q <= '0;
            else if (rd_en) dout_q <= mem[rptr[DEPTH_LOG2-1:0]];
        end
        assign dout = dout_q;
    end
endmodule

module prga_fifo_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 9,
    parameter int LOOKAHEAD  = 0,
    parameter int CONVERTED  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  full,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  empty,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout
);
    localparam int CORE_LA = (CONVERTED != 0) ? ((LOOKAHEAD != 0) ? 0 : 1)
                                              : ((LOOKAHEAD != 0) ? 1 : 0);

    logic                  core_empty, core_rd;
    logic [DATA_WIDTH-1:0] core_dout;

    prga_fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LOOKAHEAD  (CORE_LA)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .full  (full),
        .wr    (wr),
        .din   (din),
        .empty (core_empty),
        .rd    (core_rd),
        .dout  (core_dout)
    );

    if (CONVERTED == 0) begin : g_native
        assign core_rd = rd;
        assign empty   = core_empty;
        assign dout    = core_dout;
    end else if (LOOKAHEAD != 0) begin : g_to_la
        // The core's registered output is the one-entry buffer; buf_vld marks it unconsumed.
        logic buf_vld;
        assign core_rd = !core_empty && (!buf_vld || rd);
        always_ff @(posedge clk) begin
            if (rst)          buf_vld <= 1'b0;
            else if (core_rd) buf_vld <= 1'b1;
            else if (rd)      buf_vld <= 1'b0;
        end
        assign empty = !buf_vld;
        assign dout  = buf_vld ? core_dout : '0;
    end else begin : g_to_nla
        logic [DATA_WIDTH-1:0] dout_q;
        assign core_rd = rd;
        always_ff @(posedge clk) begin
            if (rst)                     dout_q <= '0;
            else if (rd && !core_empty)  dout_q <= core_dout;
        end
        assign empty = core_empty;
        assign dout  = dout_q;
    end
endmodule

// File: tb/tb_prga_fifo_sync.sv
// Bench for prga_fifo_sync: four configurations (L,C) = 00,01,10,11 side by side,
// table-driven directed vectors plus scoreboarded fill/drain, random and reset sequences.

module tb_prga_fifo_sync;
    localparam int DW = 32;
    localparam int DL = 9;
    localparam int N  = 4;
    localparam int DEPTH = 1 << DL;

    logic clk = 1'b0;
    logic rst;
    logic wr [N];
    logic rd [N];
    logic full [N];
    logic empty [N];
    logic [DW-1:0] din [N];
    logic [DW-1:0] dout [N];

    int total = 0;
    int bad = 0;
    int rcnt [N];
    logic [DW-1:0] sbq [N][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        prga_fifo_sync #(
            .DATA_WIDTH (DW),
            .DEPTH_LOG2 (DL),
            .LOOKAHEAD  (g / 2),
            .CONVERTED  (g % 2)
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .full  (full[g]),
            .wr    (wr[g]),
            .din   (din[g]),
            .empty (empty[g]),
            .rd    (rd[g]),
            .dout  (dout[g])
        );
    end

    typedef struct {
        logic                 w;
        logic                 r;
        logic [DW-1:0]        d;
        logic [3:0]           e_empty;
        logic [3:0][DW-1:0]   e_dout;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic r, input logic [DW-1:0] d,
                                input logic [3:0] e, input logic [DW-1:0] d0,
                                input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                input logic [DW-1:0] d3);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.e_empty = e;
        v.e_dout[0] = d0; v.e_dout[1] = d1; v.e_dout[2] = d2; v.e_dout[3] = d3;
        return v;
    endfunction

    task automatic chk(input string nm, input int inst, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s u%0d got=%h want=%h @%0t", nm, inst, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        for (int i = 0; i < N; i++) begin
            wr[i] = 1'b0; rd[i] = 1'b0; din[i] = '0;
        end
    endtask

    task automatic clear_sb();
        for (int i = 0; i < N; i++) begin
            sbq[i].delete();
            rcnt[i] = 0;
        end
    endtask

    task automatic pop_chk(input int i);
        logic [DW-1:0] exp;
        if (sbq[i].size() == 0) begin
            total++; bad++;
            $display("FAIL sb_underflow u%0d got=%h want=<none>", i, dout[i]);
        end else begin
            exp = sbq[i].pop_front();
            chk("stream", i, dout[i], exp);
            rcnt[i]++;
        end
    endtask

    // Inputs are already set (at a negedge); record accepted writes, check reads.
    task automatic cyc();
        bit pend [N];
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            if (wr[i] && !full[i]) sbq[i].push_back(din[i]);
            if (rd[i] && !empty[i]) begin
                if (i >= 2) pop_chk(i);
                else pend[i] = 1'b1;
            end
        end
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < N; i++) if (pend[i]) pop_chk(i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        clear_sb();
    endtask

    task automatic drain(input logic [3:0] mask);
        int guard = 0;
        bit busy = 1'b1;
        while (busy && guard < 3000) begin
            busy = 1'b0;
            for (int i = 0; i < N; i++) begin
                wr[i] = 1'b0;
                rd[i] = mask[i] && (sbq[i].size() > 0);
                if (rd[i]) busy = 1'b1;
            end
            if (busy) cyc();
            guard++;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL drain_timeout mask=%b", mask);
        end
        set_idle();
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < N; i++)
            if (mask[i]) chk("empty_after_drain", i, DW'(empty[i]), DW'(1));
    endtask

    task automatic fill(input logic [DW-1:0] base);
        for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < N; i++) begin
                wr[i] = (i < 3); rd[i] = 1'b0; din[i] = base + DW'(k);
            end
            cyc();
        end
        set_idle();
        for (int i = 0; i < 3; i++) begin
            chk("full_after_fill", i, DW'(full[i]), DW'(1));
            chk("nonempty_after_fill", i, DW'(empty[i]), DW'(0));
        end
    endtask

    initial begin
        vec_t tab [12];
        logic [DW-1:0] src [1024];
        int wcnt [N];
        int cycn;
        bit more;

        rst = 1'b1;
        set_idle();
        clear_sb();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("rst_empty", i, DW'(empty[i]), DW'(1));
            chk("rst_full", i, DW'(full[i]), DW'(0));
            chk("rst_dout", i, dout[i], '0);
        end

        // Directed vectors: empty bits listed u3..u0, dout per instance u0..u3.
        tab[0]  = mk(0, 0, 'h00, 4'b1111, 'h00, 'h00, 'h00, 'h00);
        tab[1]  = mk(0, 1, 'h00, 4'b1111, 'h00, 'h00, 'h00, 'h00);
        tab[2]  = mk(1, 0, 'h11, 4'b1000, 'h00, 'h00, 'h11, 'h00);
        tab[3]  = mk(1, 0, 'h22, 4'b0000, 'h00, 'h00, 'h11, 'h11);
        tab[4]  = mk(1, 0, 'h33, 4'b0000, 'h00, 'h00, 'h11, 'h11);
        tab[5]  = mk(0, 1, 'h00, 4'b0000, 'h11, 'h11, 'h22, 'h22);
        tab[6]  = mk(0, 1, 'h00, 4'b0000, 'h22, 'h22, 'h33, 'h33);
        tab[7]  = mk(0, 1, 'h00, 4'b1111, 'h33, 'h33, 'h00, 'h00);
        tab[8]  = mk(0, 1, 'h00, 4'b1111, 'h33, 'h33, 'h00, 'h00);
        tab[9]  = mk(1, 0, 'hA5, 4'b1000, 'h33, 'h33, 'hA5, 'h00);
        tab[10] = mk(0, 0, 'h00, 4'b0000, 'h33, 'h33, 'hA5, 'hA5);
        tab[11] = mk(0, 1, 'h00, 4'b1111, 'hA5, 'hA5, 'h00, 'h00);
        for (int s = 0; s < 12; s++) begin
            for (int i = 0; i < N; i++) begin
                wr[i] = tab[s].w; rd[i] = tab[s].r; din[i] = tab[s].d;
            end
            @(posedge clk); @(negedge clk);
            for (int i = 0; i < N; i++) begin
                chk($sformatf("vec%0d_empty", s), i, DW'(empty[i]), DW'(tab[s].e_empty[i]));
                chk($sformatf("vec%0d_dout", s), i, dout[i], tab[s].e_dout[i]);
                chk($sformatf("vec%0d_full", s), i, DW'(full[i]), DW'(0));
            end
        end

        // Fill to capacity, drop a write while full (with a concurrent read), drain, refill.
        do_reset();
        fill('0);
        for (int i = 0; i < N; i++) begin
            wr[i] = (i < 3); rd[i] = (i < 3); din[i] = 'hDEAD;
        end
        cyc();
        set_idle();
        for (int i = 0; i < 3; i++) chk("full_after_drop", i, DW'(full[i]), DW'(0));
        drain(4'b0111);
        for (int i = 0; i < 3; i++) chk("drain_count", i, DW'(rcnt[i]), DW'(DEPTH));
        fill('h1000);
        drain(4'b0111);
        for (int i = 0; i < 3; i++) chk("refill_count", i, DW'(rcnt[i]), DW'(2 * DEPTH));

        // Random stream: same 1024-word source per instance, independent wr/rd.
        do_reset();
        for (int k = 0; k < 1024; k++) src[k] = $urandom;
        for (int i = 0; i < N; i++) wcnt[i] = 0;
        cycn = 0;
        more = 1'b1;
        while (more && cycn < 20000) begin
            for (int i = 0; i < N; i++) begin
                wr[i]  = (wcnt[i] < 1024) && ($urandom_range(0, 3) != 0);
                din[i] = (wcnt[i] < 1024) ? src[wcnt[i]] : '0;
                if (wr[i] && !full[i]) wcnt[i]++;
                rd[i]  = (cycn < 1200) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            end
            cyc();
            cycn++;
            more = 1'b0;
            for (int i = 0; i < N; i++) if (rcnt[i] < 1024) more = 1'b1;
        end
        set_idle();
        for (int i = 0; i < N; i++) begin
            chk("rand_len", i, DW'(rcnt[i]), DW'(1024));
            chk("rand_left", i, DW'(sbq[i].size()), DW'(0));
        end

        // Reset with 10 entries stored discards everything.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N; i++) begin
                wr[i] = 1'b1; rd[i] = 1'b0; din[i] = 'h100 + DW'(k);
            end
            cyc();
        end
        set_idle();
        for (int i = 0; i < N; i++) chk("pre_rst_empty", i, DW'(empty[i]), DW'(0));
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        clear_sb();
        for (int i = 0; i < N; i++) begin
            chk("midrst_empty", i, DW'(empty[i]), DW'(1));
            chk("midrst_full", i, DW'(full[i]), DW'(0));
            chk("midrst_dout", i, dout[i], '0);
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                wr[i] = 1'b1; rd[i] = 1'b0; din[i] = (k == 0) ? 'h77 : 'h88;
            end
            cyc();
        end
        drain(4'b1111);
        for (int i = 0; i < N; i++) chk("post_rst_count", i, DW'(rcnt[i]), DW'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
